// File: rtl/turn_signal_ctrl.sv
// Turn-signal mode controller: arbitrates stalk/hazard requests and paces the tail-light sequencer.
// One-touch lane change is compiled in only when TURN_SIGNAL_CTRL_TAP_EN is defined.
module turn_signal_ctrl #(
  parameter int TICK_DIV   = 4,
  parameter int TAP_SWEEPS = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lt_req,
  input  logic rt_req,
  input  logic haz_btn,
  output logic lt,
  output logic rt,
  output logic haz,
  output logic step_en,
  output logic seq_clr,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } mode_e;

  localparam logic [7:0] PRESC_MAX = 8'(TICK_DIV - 1);

  if (TICK_DIV < 2 || TICK_DIV > 255 || TAP_SWEEPS < 1) begin : g_bad_param
    $error("turn_signal_ctrl: TICK_DIV must be 2..255 and TAP_SWEEPS >= 1");
  end

  mode_e      mode_q, mode_d, req;
  logic [7:0] presc_q, presc_d;
  logic [2:0] step_q, step_d;
  logic       haz_prev_q;
  logic       haz_latch_q, haz_latch_d;
  logic       seq_clr_q, seq_clr_d;
  logic       last_step, sweep_end;

`ifdef TURN_SIGNAL_CTRL_TAP_EN
  localparam int SW_W = (TAP_SWEEPS < 2) ? 1 : $clog2(TAP_SWEEPS + 1);
  logic [SW_W-1:0] sweep_q, sweep_d;
  logic            tap_q, tap_d;
`endif

  // Simultaneous left+right stalk is meaningless, so it requests IDLE.
  always_comb begin
    req = IDLE;
    if (haz_latch_q)                req = HAZARD;
    else if (lt_req && !rt_req)     req = LEFT;
    else if (rt_req && !lt_req)     req = RIGHT;
  end

  assign haz_latch_d = haz_latch_q ^ (haz_btn & ~haz_prev_q);
  assign step_en     = (mode_q != IDLE) && (presc_q == PRESC_MAX);
  assign last_step   = (step_q == ((mode_q == HAZARD) ? 3'd5 : 3'd3));
  assign sweep_end   = step_en && last_step;

  always_comb begin
    mode_d = mode_q;
`ifdef TURN_SIGNAL_CTRL_TAP_EN
    tap_d   = tap_q;
    sweep_d = sweep_q;
`endif
    if (mode_q == IDLE) begin
      mode_d = req;
    end else if (req == HAZARD && mode_q != HAZARD) begin
      mode_d = HAZARD;
    end else if (sweep_end && req != mode_q) begin
`ifdef TURN_SIGNAL_CTRL_TAP_EN
      // A tapped stalk keeps the lamp running until the tap sweep budget is spent.
      if (tap_q && req == IDLE && (int'(sweep_q) + 1) < TAP_SWEEPS) mode_d = mode_q;
      else                                                         mode_d = req;
`else
      mode_d = req;
`endif
    end

`ifdef TURN_SIGNAL_CTRL_TAP_EN
    if (mode_q == LEFT || mode_q == RIGHT) begin
      if (sweep_end && int'(sweep_q) < TAP_SWEEPS) sweep_d = sweep_q + 1'b1;
      if (sweep_q == '0 && req == IDLE)           tap_d   = 1'b1;
    end
    if (mode_d != mode_q) begin
      tap_d   = 1'b0;
      sweep_d = '0;
    end
`endif

    seq_clr_d = (mode_d != mode_q);

    presc_d = presc_q + 8'd1;
    if (seq_clr_d || mode_q == IDLE || step_en) presc_d = 8'd0;

    step_d = step_q;
    if (seq_clr_d || mode_q == IDLE) step_d = 3'd0;
    else if (step_en)                step_d = last_step ? 3'd0 : step_q + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= IDLE;
      presc_q     <= 8'd0;
      step_q      <= 3'd0;
      haz_prev_q  <= 1'b0;
      haz_latch_q <= 1'b0;
      seq_clr_q   <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      presc_q     <= presc_d;
      step_q      <= step_d;
      haz_prev_q  <= haz_btn;
      haz_latch_q <= haz_latch_d;
      seq_clr_q   <= seq_clr_d;
    end
  end

`ifdef TURN_SIGNAL_CTRL_TAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_q   <= 1'b0;
      sweep_q <= '0;
    end else begin
      tap_q   <= tap_d;
      sweep_q <= sweep_d;
    end
  end
`endif

  assign lt      = (mode_q == LEFT);
  assign rt      = (mode_q == RIGHT);
  assign haz     = (mode_q == HAZARD);
  assign busy    = (mode_q != IDLE);
  assign seq_clr = seq_clr_q;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Directed bench for turn_signal_ctrl (TICK_DIV=4, TAP_SWEEPS=3); expectations are hand-derived cycle numbers.
module tb_turn_signal_ctrl;

  logic clk = 1'b0;
  logic rst_n, lt_req, rt_req, haz_btn;
  logic lt, rt, haz, step_en, seq_clr, busy;

  int checks = 0;
  int errors = 0;

  turn_signal_ctrl #(.TICK_DIV(4), .TAP_SWEEPS(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .lt_req (lt_req),
    .rt_req (rt_req),
    .haz_btn(haz_btn),
    .lt     (lt),
    .rt     (rt),
    .haz    (haz),
    .step_en(step_en),
    .seq_clr(seq_clr),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0 with reset released and all inputs low.
  task automatic reset_dut();
    rst_n   = 1'b0;
    lt_req  = 1'b0;
    rt_req  = 1'b0;
    haz_btn = 1'b0;
    tick();
    tick();
    check_eq("reset_outs", {26'd0, lt, rt, haz, step_en, seq_clr, busy}, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    // Left stalk held: entry pulse at 1, steps every 4 clocks, sweep wraps without mode change.
    reset_dut();
    lt_req = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      check_eq($sformatf("left_lt_c%0d", c), {31'd0, lt}, 32'd1);
      check_eq($sformatf("left_stp_c%0d", c), {31'd0, step_en}, {31'd0, (c % 4) == 0});
      check_eq($sformatf("left_clr_c%0d", c), {31'd0, seq_clr}, {31'd0, c == 1});
    end

    // Left to right at cycle 6 waits for the sweep end at 16.
    reset_dut();
    lt_req = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      check_eq($sformatf("l2r_lt_c%0d", c), {31'd0, lt}, {31'd0, c <= 16});
      check_eq($sformatf("l2r_rt_c%0d", c), {31'd0, rt}, {31'd0, c >= 17});
      check_eq($sformatf("l2r_clr_c%0d", c), {31'd0, seq_clr}, {31'd0, c == 1 || c == 17});
      check_eq($sformatf("l2r_excl_c%0d", c), {31'd0, lt & rt}, 32'd0);
      if (c == 6) begin
        lt_req = 1'b0;
        rt_req = 1'b1;
      end
    end

    // Hazard press at cycle 6 of a right sweep preempts at 8; sweeps become 6 steps.
    reset_dut();
    rt_req = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      check_eq($sformatf("hz_rt_c%0d", c), {31'd0, rt}, {31'd0, c <= 7});
      check_eq($sformatf("hz_haz_c%0d", c), {31'd0, haz}, {31'd0, c >= 8});
      check_eq($sformatf("hz_clr_c%0d", c), {31'd0, seq_clr}, {31'd0, c == 1 || c == 8});
      if (c >= 8)
        check_eq($sformatf("hz_stp_c%0d", c), {31'd0, step_en},
                 {31'd0, c >= 11 && ((c - 11) % 4) == 0});
      if (c == 6)  haz_btn = 1'b1;
      if (c == 10) haz_btn = 1'b0;
    end

    // Hazard cancelled at cycle 6 holds until its sweep end at 25, then IDLE.
    reset_dut();
    haz_btn = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      check_eq($sformatf("hoff_haz_c%0d", c), {31'd0, haz}, {31'd0, c >= 2 && c <= 25});
      check_eq($sformatf("hoff_busy_c%0d", c), {31'd0, busy}, {31'd0, c >= 2 && c <= 25});
      check_eq($sformatf("hoff_clr_c%0d", c), {31'd0, seq_clr}, {31'd0, c == 2 || c == 26});
      check_eq($sformatf("hoff_lr_c%0d", c), {30'd0, lt, rt}, 32'd0);
      if (c >= 27) check_eq($sformatf("hoff_stp_c%0d", c), {31'd0, step_en}, 32'd0);
      if (c == 4) haz_btn = 1'b0;
      if (c == 6) haz_btn = 1'b1;
    end

    // Both stalks at once is an IDLE request.
    reset_dut();
    lt_req = 1'b1;
    rt_req = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check_eq($sformatf("both_busy_c%0d", c), {29'd0, busy, lt, rt}, 32'd0);
    end

    // Stalk tap for cycles 0-2: three sweeps with tap support, one sweep without.
    reset_dut();
    lt_req = 1'b1;
    for (int c = 1; c <= 52; c++) begin
      tick();
`ifdef TURN_SIGNAL_CTRL_TAP_EN
      check_eq($sformatf("tap_lt_c%0d", c), {31'd0, lt}, {31'd0, c <= 48});
      check_eq($sformatf("tap_clr_c%0d", c), {31'd0, seq_clr}, {31'd0, c == 1 || c == 49});
`else
      check_eq($sformatf("tap_lt_c%0d", c), {31'd0, lt}, {31'd0, c <= 16});
      check_eq($sformatf("tap_clr_c%0d", c), {31'd0, seq_clr}, {31'd0, c == 1 || c == 17});
`endif
      if (c == 2) lt_req = 1'b0;
    end

    // Asynchronous reset at cycle 10 of a left sweep, with the hazard latch already set.
    reset_dut();
    lt_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 9) haz_btn = 1'b1;
    end
    check_eq("arst_pre_lt", {31'd0, lt}, 32'd1);
    #2;
    rst_n   = 1'b0;
    lt_req  = 1'b0;
    haz_btn = 1'b0;
    #1;
    check_eq("arst_same_cycle", {26'd0, lt, rt, haz, step_en, seq_clr, busy}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check_eq($sformatf("arst_latch_clr_c%0d", c), {26'd0, lt, rt, haz, step_en, seq_clr, busy}, 32'd0);
    end
    lt_req = 1'b1;
    tick();
    check_eq("arst_restart", {30'd0, lt, seq_clr}, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/turn_signal_ctrl.md
TURN_SIGNAL_CTRL -- requirements
Module: turn_signal_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4: clocks per lamp step, legal 2..255.
REQ-002 SHALL have parameter TAP_SWEEPS, default 3: sweeps completed after a stalk tap.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port lt_req, input, 1: left stalk level.
REQ-006 SHALL have port rt_req, input, 1: right stalk level.
REQ-007 SHALL have port haz_btn, input, 1: hazard push-button level; each rising edge toggles hazard.
REQ-008 SHALL have ports lt, rt, haz, output, 1 each: registered, one-hot-or-zero commands to the tail-light sequencer.
REQ-009 SHALL have port step_en, output, 1: one-cycle strobe advancing the sequencer one step.
REQ-010 SHALL have port seq_clr, output, 1: one-cycle pulse returning the sequencer to its first step.
REQ-011 SHALL have port busy, output, 1: high whenever the mode is not IDLE.

Function
REQ-012 SHALL implement modes IDLE, LEFT, RIGHT, HAZARD; lt/rt/haz/busy decode the registered mode.
REQ-013 SHALL detect haz_btn rising edges from a registered copy and toggle haz_latch on each edge.
REQ-014 SHALL form the request: haz_latch -> HAZARD; else lt_req only -> LEFT; else rt_req only -> RIGHT; else (none or both) -> IDLE.
REQ-015 SHALL run a prescaler 0..TICK_DIV-1 outside IDLE, held at 0 in IDLE; step_en = 1 in the cycle it equals TICK_DIV-1.
REQ-016 SHALL count step_en pulses in a step counter wrapping after 4 steps (LEFT/RIGHT) or 6 steps (HAZARD); sweep_end = step_en on the last step.
REQ-017 SHALL leave IDLE on the cycle after a non-IDLE request appears, with seq_clr = 1 in that first non-IDLE cycle.
REQ-018 SHALL enter HAZARD on the cycle after haz_latch sets, from any mode, without waiting for sweep_end.
REQ-019 SHALL apply every other mode change (exit HAZARD, LEFT<->RIGHT, to IDLE) only on the cycle after sweep_end.
REQ-020 SHALL zero the prescaler and step counter and pulse seq_clr for exactly one cycle on every mode change.
REQ-021 SHALL never assert lt and rt in the same cycle; the lt_req&&rt_req request is treated as IDLE.
REQ-022 SHALL hold haz_btn edges arriving at HAZARD exit consistent: the latch value sampled at sweep_end decides the next mode.

Reset
REQ-023 SHALL, while rst_n = 0, force mode IDLE, haz_latch 0, edge register 0, counters 0, and all outputs 0.
REQ-024 SHALL on rst_n assertion mid-sequence clear immediately (asynchronously) with no seq_clr pulse; after release, act as from IDLE.

Configuration
REQ-025 SHALL compile one-touch lane change only when macro TURN_SIGNAL_CTRL_TAP_EN is defined.
REQ-026 With TURN_SIGNAL_CTRL_TAP_EN: if the stalk drops before the first sweep_end of a LEFT/RIGHT episode, the mode SHALL continue for TAP_SWEEPS sweeps total, then return to IDLE; an opposite request or hazard still ends it per REQ-018/019.
REQ-027 Without TURN_SIGNAL_CTRL_TAP_EN: a LEFT/RIGHT mode SHALL end at the first sweep_end after its request drops; no tap counter SHALL exist.

Verification
REQ-028 Reset, then lt_req = 1 at cycle 0 -> lt = 1, seq_clr = 1 at cycle 1; step_en at cycles 4, 8, 12, 16; sweep_end at cycle 16.
REQ-029 LEFT active, rt_req = 1 and lt_req = 0 at cycle 6 -> lt stays 1 through the sweep_end at cycle 16; rt = 1, seq_clr = 1 at cycle 17; lt and rt never both 1.
REQ-030 RIGHT active mid-sweep, haz_btn rising edge -> haz = 1, rt = 0, seq_clr = 1 two cycles after the edge; sweep length becomes 6 steps (24 clocks).
REQ-031 HAZARD active, second haz_btn edge with no stalk -> haz held until next sweep_end; then busy = 0, all outputs 0.
REQ-032 TAP_EN defined: lt_req high for cycles 0-2 only -> lt high for 3 sweeps (48 clocks), then IDLE; TAP_EN undefined: lt drops after 1 sweep.
REQ-033 rst_n = 0 at cycle 10 of a LEFT sweep -> lt, step_en, busy = 0 in that same cycle; haz_latch cleared.
